// File: rtl/bcd_convert_ctrl.sv
// rtl/bcd_convert_ctrl.sv - iterative shift/add-3 binary-to-BCD converter with start/busy/done handshake
module bcd_convert_ctrl #(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] bin_in,
    input  logic         start,
    input  logic         auto_en,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic [3:0]   D_unidades,
    output logic [3:0]   D_decenas,
    output logic [3:0]   D_centenas,
    output logic [3:0]   D_miles
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ADJ, SHF, DONE} state_t;

    state_t          state;
    logic [N-1:0]    shift_reg;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   scratch_adj;
    logic [15:0]     scratch16;
    logic [CW-1:0]   bit_cnt;
    logic            ovf_acc;
    logic [N-1:0]    last;
    logic            last_valid;
    logic            launch;

    // Auto mode relaunches only on a fresh value, so a held input converts once.
    assign launch = start || (auto_en && (!last_valid || (bin_in != last)));

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        scratch16 = 16'(scratch);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            scratch    <= '0;
            bit_cnt    <= '0;
            ovf_acc    <= 1'b0;
            last       <= '0;
            last_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            D_unidades <= 4'd0;
            D_decenas  <= 4'd0;
            D_centenas <= 4'd0;
            D_miles    <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        shift_reg  <= bin_in;
                        last       <= bin_in;
                        last_valid <= 1'b1;
                        scratch    <= '0;
                        bit_cnt    <= CW'(N);
                        ovf_acc    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ADJ;
                    end
                end
                ADJ: begin
                    scratch <= scratch_adj;
                    state   <= SHF;
                end
                SHF: begin
                    {scratch, shift_reg} <= {scratch, shift_reg} << 1;
                    ovf_acc <= ovf_acc | scratch[SW-1];
                    bit_cnt <= bit_cnt - CW'(1);
                    state   <= (bit_cnt == CW'(1)) ? DONE : ADJ;
                end
                DONE: begin
                    D_unidades <= scratch16[3:0];
                    D_decenas  <= scratch16[7:4];
                    D_centenas <= scratch16[11:8];
                    D_miles    <= scratch16[15:12];
                    overflow   <= ovf_acc;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
